// File: rtl/nx_rst_load_gen.sv
// -----------------------------------------------------------------------------
// nx_rst_load_gen
//   Reset/load sequencer for a bank of NX_DFF cells. It synchronises the
//   release of the asynchronous reset, holds the downstream synchronous reset R
//   for STRETCH cycles, then enters RUN and produces a divided load strobe L.
//
// Parameters
//   STRETCH  1..256  cycles R stays high after reset release or a soft reset
//   DIV      1..256  L strobe period, counted in enabled RUN cycles
//
// Ports
//   CK        in   clock, rising edge
//   RN        in   asynchronous active-low reset
//   SRST_REQ  in   synchronous soft-reset request (active only with the macro)
//   EN        in   load-strobe generation enable
//   R         out  registered synchronous reset to NX_DFF R pins, active-high
//   L         out  registered load enable to NX_DFF L pins, active-high
//   READY     out  registered, high while in RUN
//
// Build option
//   NX_RST_LOAD_GEN_SRST_EN  when defined, SRST_REQ restarts the stretch from
//                            STRETCH or RUN. When undefined the port remains
//                            but is ignored and RUN is left only through RN.
// -----------------------------------------------------------------------------
module nx_rst_load_gen #(
    parameter int STRETCH = 4,
    parameter int DIV     = 1
) (
    input  logic CK,
    input  logic RN,
    input  logic SRST_REQ,
    input  logic EN,
    output logic R,
    output logic L,
    output logic READY
);

    generate
        if (STRETCH < 1 || STRETCH > 256) begin : g_bad_stretch
            $error("nx_rst_load_gen: STRETCH out of range 1..256");
        end
        if (DIV < 1 || DIV > 256) begin : g_bad_div
            $error("nx_rst_load_gen: DIV out of range 1..256");
        end
    endgenerate

    localparam logic [7:0] SLOAD = 8'(STRETCH - 1);
    localparam logic [7:0] DLAST = 8'(DIV - 1);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       s0_q, s1_q;
    logic [7:0] scnt_q, scnt_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic       r_q, r_d;
    logic       l_q, l_d;
    logic       rdy_q, rdy_d;

`ifdef NX_RST_LOAD_GEN_SRST_EN
    logic srst;
    assign srst = SRST_REQ;
`else
    logic srst_unused;
    assign srst_unused = SRST_REQ;
`endif

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            state_q <= ST_RESET;
            scnt_q  <= 8'd0;
            dcnt_q  <= 8'd0;
            r_q     <= 1'b1;
            l_q     <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            s0_q    <= 1'b1;
            s1_q    <= s0_q;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            dcnt_q  <= dcnt_d;
            r_q     <= r_d;
            l_q     <= l_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        dcnt_d  = dcnt_q;
        l_d     = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (s1_q) begin
                    state_d = ST_STRETCH;
                    scnt_d  = SLOAD;
                end
            end
            ST_STRETCH: begin
                // Counter reaching 0 means STRETCH cycles of R have elapsed.
                if (scnt_q == 8'd0) begin
                    state_d = ST_RUN;
                    dcnt_d  = 8'd0;
                end else begin
                    scnt_d = scnt_q - 8'd1;
                end
            end
            ST_RUN: begin
                // L is the registered wrap of the divider, so it pulses on the
                // edge where dcnt returns to 0.
                if (EN) begin
                    if (dcnt_q == DLAST) begin
                        dcnt_d = 8'd0;
                        l_d    = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
`ifdef NX_RST_LOAD_GEN_SRST_EN
        // A soft reset overrides any stretch progress or divider wrap.
        if (srst && state_q != ST_RESET) begin
            state_d = ST_STRETCH;
            scnt_d  = SLOAD;
            dcnt_d  = 8'd0;
            l_d     = 1'b0;
        end
`endif
    end

    // Outputs are registered from the next state so they change on the very
    // edge that enters a state.
    assign r_d   = (state_d != ST_RUN);
    assign rdy_d = (state_d == ST_RUN);

    assign R     = r_q;
    assign L     = l_q;
    assign READY = rdy_q;

endmodule

// File: tb/tb_nx_rst_load_gen.sv
// -----------------------------------------------------------------------------
// tb_nx_rst_load_gen
//   Three instances (STRETCH/DIV = 4/1, 4/3, 2/3) share one stimulus stream and
//   are compared each cycle against a behavioural model that tracks remaining
//   reset cycles and enabled-cycle counts.
// -----------------------------------------------------------------------------
module tb_nx_rst_load_gen;

`ifdef NX_RST_LOAD_GEN_SRST_EN
    localparam bit SRST_ON = 1'b1;
`else
    localparam bit SRST_ON = 1'b0;
`endif

    logic       CK;
    logic       RN;
    logic       SRST_REQ;
    logic       EN;
    logic [2:0] R_o, L_o, RDY_o;

    int n_cmp;
    int n_bad;

    nx_rst_load_gen #(.STRETCH(4), .DIV(1)) u_a (
        .CK(CK), .RN(RN), .SRST_REQ(SRST_REQ), .EN(EN),
        .R(R_o[0]), .L(L_o[0]), .READY(RDY_o[0]));
    nx_rst_load_gen #(.STRETCH(4), .DIV(3)) u_b (
        .CK(CK), .RN(RN), .SRST_REQ(SRST_REQ), .EN(EN),
        .R(R_o[1]), .L(L_o[1]), .READY(RDY_o[1]));
    nx_rst_load_gen #(.STRETCH(2), .DIV(3)) u_c (
        .CK(CK), .RN(RN), .SRST_REQ(SRST_REQ), .EN(EN),
        .R(R_o[2]), .L(L_o[2]), .READY(RDY_o[2]));

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // ---------------- reference model ----------------
    // phase: 0 = held in reset, 1 = R asserted, 2 = running
    int m_phase[3];
    int m_sync[3];   // edges seen since RN release (saturates at 2)
    int m_rem[3];    // R-high cycles still to go, counting the current one
    int m_ecnt[3];   // enabled RUN cycles since the last strobe
    bit m_R[3], m_L[3], m_RDY[3];

    function automatic int s_of(int k);
        return (k == 2) ? 2 : 4;
    endfunction

    function automatic int d_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_phase[k] = 0; m_sync[k] = 0; m_rem[k] = 0; m_ecnt[k] = 0;
            m_R[k] = 1'b1; m_L[k] = 1'b0; m_RDY[k] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        if (!RN) return;
        for (int k = 0; k < 3; k++) begin
            bit lout;
            lout = 1'b0;
            if (m_phase[k] == 0) begin
                if (m_sync[k] == 2) begin
                    m_phase[k] = 1;
                    m_rem[k]   = s_of(k);
                end else begin
                    m_sync[k]++;
                end
            end else if (SRST_ON && SRST_REQ) begin
                m_phase[k] = 1;
                m_rem[k]   = s_of(k);
                m_ecnt[k]  = 0;
            end else if (m_phase[k] == 1) begin
                if (m_rem[k] == 1) begin
                    m_phase[k] = 2;
                    m_ecnt[k]  = 0;
                end else begin
                    m_rem[k]--;
                end
            end else if (EN) begin
                m_ecnt[k]++;
                if (m_ecnt[k] == d_of(k)) begin
                    m_ecnt[k] = 0;
                    lout      = 1'b1;
                end
            end
            m_R[k]   = (m_phase[k] != 2);
            m_RDY[k] = (m_phase[k] == 2);
            m_L[k]   = lout;
        end
    endfunction

    function automatic logic [8:0] exp_vec();
        return {m_R[2], m_R[1], m_R[0], m_L[2], m_L[1], m_L[0],
                m_RDY[2], m_RDY[1], m_RDY[0]};
    endfunction

    // One clock: model advances with the DUT edge, outputs sampled on negedge.
    task automatic tick();
        @(posedge CK);
        model_edge();
        @(negedge CK);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RN = 1'b1; EN = 1'b0; SRST_REQ = 1'b0;
        #1 RN = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({R_o, L_o, RDY_o} !== 9'b111_000_000) begin
            n_bad++;
            $display("FAIL reset_async got RLY=%b want %b", {R_o, L_o, RDY_o}, 9'b111_000_000);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({R_o, L_o, RDY_o} !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d got RLY=%b want %b", i, {R_o, L_o, RDY_o}, exp_vec());
            end
        end
    endtask

    task automatic test_startup();
        logic [2:0] want_a;
        // Release lands between edges; the next edge is e1.
        RN = 1'b1; EN = 1'b1;
        #1;
        n_cmp++;
        if ({R_o, L_o, RDY_o} !== 9'b111_000_000) begin
            n_bad++;
            $display("FAIL release_quiet got RLY=%b want %b", {R_o, L_o, RDY_o}, 9'b111_000_000);
        end
        for (int e = 1; e <= 16; e++) begin
            tick();
            n_cmp++;
            if ({R_o, L_o, RDY_o} !== exp_vec()) begin
                n_bad++;
                $display("FAIL startup_model e%0d got RLY=%b want %b", e, {R_o, L_o, RDY_o}, exp_vec());
            end
            want_a = {1'(e <= 6), 1'(e >= 8), 1'(e >= 7)};
            n_cmp++;
            if ({R_o[0], L_o[0], RDY_o[0]} !== want_a) begin
                n_bad++;
                $display("FAIL startup_s4d1 e%0d got R,L,RDY=%b want %b", e, {R_o[0], L_o[0], RDY_o[0]}, want_a);
            end
            n_cmp++;
            if (L_o[1] !== 1'(e == 10 || e == 13 || e == 16)) begin
                n_bad++;
                $display("FAIL div3_pulse e%0d got L=%b want %b", e, L_o[1], 1'(e == 10 || e == 13 || e == 16));
            end
        end
    endtask

    task automatic test_en_gap();
        for (int i = 0; i < 10; i++) begin
            EN = !(i == 1 || i == 2);
            tick();
            n_cmp++;
            if ({R_o, L_o, RDY_o} !== exp_vec()) begin
                n_bad++;
                $display("FAIL en_gap cyc%0d got RLY=%b want %b", i, {R_o, L_o, RDY_o}, exp_vec());
            end
        end
        EN = 1'b1;
    endtask

    task automatic test_soft_reset();
        int rhigh;
        rhigh = 0;
        SRST_REQ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            SRST_REQ = 1'b0;
            if (R_o[2]) rhigh++;
            n_cmp++;
            if ({R_o, L_o, RDY_o} !== exp_vec()) begin
                n_bad++;
                $display("FAIL soft_reset cyc%0d got RLY=%b want %b", i, {R_o, L_o, RDY_o}, exp_vec());
            end
        end
        n_cmp++;
        if (rhigh !== (SRST_ON ? 2 : 0)) begin
            n_bad++;
            $display("FAIL soft_reset_len got %0d R cycles want %0d", rhigh, SRST_ON ? 2 : 0);
        end
    endtask

    task automatic test_srst_restart();
        int rhigh;
        rhigh = 0;
        SRST_REQ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            SRST_REQ = (i == 0);   // second request lands in the first stretch cycle
            if (R_o[0]) rhigh++;
            n_cmp++;
            if ({R_o, L_o, RDY_o} !== exp_vec()) begin
                n_bad++;
                $display("FAIL srst_restart cyc%0d got RLY=%b want %b", i, {R_o, L_o, RDY_o}, exp_vec());
            end
        end
        n_cmp++;
        if (rhigh !== (SRST_ON ? 5 : 0)) begin
            n_bad++;
            $display("FAIL srst_restart_len got %0d R cycles want %0d", rhigh, SRST_ON ? 5 : 0);
        end
    endtask

    task automatic test_async_mid_run();
        #2 RN = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({R_o, L_o, RDY_o} !== 9'b111_000_000) begin
            n_bad++;
            $display("FAIL async_mid_run got RLY=%b want %b", {R_o, L_o, RDY_o}, 9'b111_000_000);
        end
        tick();
        RN = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_cmp++;
            if ({R_o[0], L_o[0], RDY_o[0]} !== {1'(e <= 6), 1'(e >= 8), 1'(e >= 7)}) begin
                n_bad++;
                $display("FAIL rerun_s4d1 e%0d got R,L,RDY=%b want %b", e, {R_o[0], L_o[0], RDY_o[0]},
                         {1'(e <= 6), 1'(e >= 8), 1'(e >= 7)});
            end
            n_cmp++;
            if ({R_o, L_o, RDY_o} !== exp_vec()) begin
                n_bad++;
                $display("FAIL rerun_model e%0d got RLY=%b want %b", e, {R_o, L_o, RDY_o}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            EN       = ($urandom_range(0, 3) != 0);
            SRST_REQ = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 79) == 0) begin
                #2 RN = 1'b0;
                model_reset();
                #1;
                n_cmp++;
                if ({R_o, L_o, RDY_o} !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL random_async cyc%0d got RLY=%b want %b", i, {R_o, L_o, RDY_o}, exp_vec());
                end
                #1 RN = 1'b1;
            end
            tick();
            n_cmp++;
            if ({R_o, L_o, RDY_o} !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc%0d got RLY=%b want %b", i, {R_o, L_o, RDY_o}, exp_vec());
            end
        end
        SRST_REQ = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_startup();
        test_en_gap();
        test_soft_reset();
        test_srst_restart();
        test_async_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
